// File: rtl/control_multiciclo_pkg.sv
// Shared constants and types for the multi-cycle MIPS32 control path.
// Also imported by ALUcontrol, which uses the same opcode constants.
package control_multiciclo_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_EXEC_I   = 4'd10,
        ST_I_WB     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [5:0] alu_fnc;
        logic       instr_ilegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // DECODE dispatch; unsupported opcodes fall back to FETCH, which doubles
    // as the illegal-instruction indication.
    function automatic state_e decode_dispatch(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW:                                nxt = ST_MEMADR;
            OP_RTYPE:                                    nxt = ST_EXEC_R;
            OP_BEQ:                                      nxt = ST_BRANCH;
            OP_J:                                        nxt = ST_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:  nxt = ST_EXEC_I;
            default:                                     nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS32 main control FSM: Moore decode of the registered state,
// with only the FETCH/memory strobes and waits qualified by mem_listo.
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_listo,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [5:0] alu_fnc,
    output logic       instr_ilegal,
    output logic [3:0] estado
);

    state_e state_q;
    state_e state_d;
    logic   mem_ok_s;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_out_s;

    assign mem_ok_s = MEM_WAIT_EN ? mem_listo : 1'b1;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ok_s) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: state_d = decode_dispatch(opcode);
            ST_MEMADR: begin
                if (opcode == OP_SW) begin
                    state_d = ST_MEMWRITE;
                end else if (opcode == OP_LW) begin
                    state_d = ST_MEMREAD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMREAD: begin
                if (mem_ok_s) begin
                    state_d = ST_MEMWB;
                end else begin
                    state_d = ST_MEMREAD;
                end
            end
            ST_MEMWRITE: begin
                if (mem_ok_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEMWRITE;
                end
            end
            ST_EXEC_R: state_d = ST_R_WB;
            ST_EXEC_I: state_d = ST_I_WB;
            ST_MEMWB,
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Per-state control decode; unlisted fields stay inactive
    always_comb begin
        ctrl_s = CTRL_IDLE;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.i_or_d    = 1'b0;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_src    = PCSRC_ALU;
                ctrl_s.ir_write  = mem_ok_s;
                ctrl_s.pc_write  = mem_ok_s;
            end
            ST_DECODE: begin
                ctrl_s.alu_src_a    = 1'b0;
                ctrl_s.alu_src_b    = SRCB_IMM_SH2;
                ctrl_s.alu_op       = ALUOP_ADD;
                ctrl_s.instr_ilegal = (decode_dispatch(opcode) == ST_FETCH);
            end
            ST_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEMREAD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
            end
            ST_MEMWRITE: begin
                ctrl_s.i_or_d    = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                ctrl_s.alu_op    = ALUOP_R;
                ctrl_s.alu_fnc   = funct;
            end
            ST_R_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a     = 1'b1;
                ctrl_s.alu_src_b     = SRCB_B;
                ctrl_s.alu_op        = ALUOP_SUB;
                ctrl_s.pc_write_cond = 1'b1;
                ctrl_s.pc_src        = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_s.pc_write = 1'b1;
                ctrl_s.pc_src   = PCSRC_JUMP;
            end
            ST_EXEC_I: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_I;
                ctrl_s.alu_fnc   = opcode;
            end
            ST_I_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b0;
            end
            default: ctrl_s = CTRL_IDLE;
        endcase
    end

    // Reset masks every control output so no write strobe fires in the reset cycle
    always_comb begin
        if (reset) begin
            ctrl_out_s = CTRL_IDLE;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign pc_write      = ctrl_out_s.pc_write;
    assign pc_write_cond = ctrl_out_s.pc_write_cond;
    assign pc_src        = ctrl_out_s.pc_src;
    assign i_or_d        = ctrl_out_s.i_or_d;
    assign mem_read      = ctrl_out_s.mem_read;
    assign mem_write     = ctrl_out_s.mem_write;
    assign ir_write      = ctrl_out_s.ir_write;
    assign mem_to_reg    = ctrl_out_s.mem_to_reg;
    assign reg_dst       = ctrl_out_s.reg_dst;
    assign reg_write     = ctrl_out_s.reg_write;
    assign alu_src_a     = ctrl_out_s.alu_src_a;
    assign alu_src_b     = ctrl_out_s.alu_src_b;
    assign alu_op        = ctrl_out_s.alu_op;
    assign alu_fnc       = ctrl_out_s.alu_fnc;
    assign instr_ilegal  = ctrl_out_s.instr_ilegal;
    assign estado        = state_q;

endmodule
